// File: rtl/addsub_arbiter.sv
// Round-robin front end that shares one pipelined add/subtract core between
// NUM_REQ requesters and routes each result back to the requester that issued it.
module addsub_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int WIDTH        = 16,
   parameter int CORE_LATENCY = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_issue_en,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   output logic [NUM_REQ-1:0]         o_req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
   input  logic [NUM_REQ-1:0]         i_req_sub,
   output logic [NUM_REQ-1:0]         o_rsp_valid,
   output logic [WIDTH-1:0]           o_rsp_z,
   output logic                       o_rsp_ovf,
   output logic [WIDTH-1:0]           o_core_A,
   output logic [WIDTH-1:0]           o_core_B,
   output logic                       o_core_AddSub,
   output logic                       o_core_Sel,
   input  logic [WIDTH-1:0]           i_core_Z,
   input  logic                       i_core_Overflow,
   output logic                       o_busy
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDW-1:0]          r_rr_ptr;
   logic [CORE_LATENCY-1:0] r_vld_p;
   logic [IDW-1:0]          r_id_p [CORE_LATENCY];

   logic                    w_gnt_vld;
   logic [IDW-1:0]          w_gnt_id;
   logic [IDW:0]            w_idx;
   logic [IDW-1:0]          w_ptr_nxt;
   logic                    w_rsp_vld;
   logic [IDW-1:0]          w_rsp_id;

   // Search starts at the pointer and wraps; reset also blocks grants so
   // nothing reaches the core while the tag pipeline is being flushed.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = '0;
      w_idx     = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(off);
         if (w_idx >= (IDW+1)'(NUM_REQ))
            w_idx = w_idx - (IDW+1)'(NUM_REQ);
         if (!w_gnt_vld && i_req_valid[w_idx[IDW-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_idx[IDW-1:0];
         end
      end
      if (!i_issue_en || i_rst) begin
         w_gnt_vld = 1'b0;
         w_gnt_id  = '0;
      end
   end

   assign w_ptr_nxt = (w_gnt_id == IDW'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;

   always_comb begin
      o_req_ready = '0;
      if (w_gnt_vld)
         o_req_ready[w_gnt_id] = 1'b1;
   end

   assign o_core_A      = w_gnt_vld ? i_req_a[w_gnt_id*WIDTH +: WIDTH] : '0;
   assign o_core_B      = w_gnt_vld ? i_req_b[w_gnt_id*WIDTH +: WIDTH] : '0;
   assign o_core_AddSub = w_gnt_vld ? i_req_sub[w_gnt_id] : 1'b0;
   assign o_core_Sel    = 1'b0;

   // Stage boundary: pointer and tag valids advance alongside the core pipeline
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr <= '0;
         r_vld_p  <= '0;
      end else begin
         if (w_gnt_vld)
            r_rr_ptr <= w_ptr_nxt;
         r_vld_p[0] <= w_gnt_vld;
         for (int s = 1; s < CORE_LATENCY; s++)
            r_vld_p[s] <= r_vld_p[s-1];
      end
   end

   // Requester ids are only meaningful where the matching valid bit is set
   always_ff @(posedge i_clk) begin
      r_id_p[0] <= w_gnt_id;
      for (int s = 1; s < CORE_LATENCY; s++)
         r_id_p[s] <= r_id_p[s-1];
   end

   assign w_rsp_vld = r_vld_p[CORE_LATENCY-1];
   assign w_rsp_id  = r_id_p[CORE_LATENCY-1];

   always_comb begin
      o_rsp_valid = '0;
      o_rsp_z     = '0;
      o_rsp_ovf   = 1'b0;
      if (w_rsp_vld) begin
         o_rsp_valid[w_rsp_id] = 1'b1;
         o_rsp_z               = i_core_Z;
         o_rsp_ovf             = i_core_Overflow;
      end
   end

   assign o_busy = |r_vld_p;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a two-stage add/sub core model attached.
module tb_addsub_arbiter;

   logic        clk;
   logic        rst;
   logic        issue_en;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_sub;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_z;
   logic        rsp_ovf;
   logic [15:0] core_A;
   logic [15:0] core_B;
   logic        core_AddSub;
   logic        core_Sel;
   logic [15:0] core_Z;
   logic        core_Overflow;
   logic        busy;

   int total = 0;
   int bad   = 0;

   addsub_arbiter #(.NUM_REQ(4), .WIDTH(16), .CORE_LATENCY(2)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_issue_en      (issue_en),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_req_a         (req_a),
      .i_req_b         (req_b),
      .i_req_sub       (req_sub),
      .o_rsp_valid     (rsp_valid),
      .o_rsp_z         (rsp_z),
      .o_rsp_ovf       (rsp_ovf),
      .o_core_A        (core_A),
      .o_core_B        (core_B),
      .o_core_AddSub   (core_AddSub),
      .o_core_Sel      (core_Sel),
      .i_core_Z        (core_Z),
      .i_core_Overflow (core_Overflow),
      .o_busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core stand-in: result and overflow appear two cycles after operands
   function automatic logic [16:0] core_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
      logic [15:0] z;
      logic        o;
      z = s ? a - b : a + b;
      o = s ? ((a[15] != b[15]) && (z[15] != a[15]))
            : ((a[15] == b[15]) && (z[15] != a[15]));
      return {o, z};
   endfunction

   logic [16:0] s1, s2;
   always @(posedge clk) begin
      s1 <= core_fn(core_A, core_B, core_AddSub);
      s2 <= s1;
   end
   assign core_Z        = s2[15:0];
   assign core_Overflow = s2[16];

   // Requester rule: a pending, unaccepted request stays valid and stable
   logic [3:0]  p_vld, p_rdy, p_sub;
   logic [63:0] p_a, p_b;
   logic        p_ok = 1'b0;
   always @(posedge clk) begin
      if (!rst && p_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (p_vld[i] && !p_rdy[i] &&
                (!req_valid[i] || req_a[i*16 +: 16] != p_a[i*16 +: 16] ||
                 req_b[i*16 +: 16] != p_b[i*16 +: 16] || req_sub[i] != p_sub[i]))
               $error("requester %0d changed a pending request", i);
         end
      end
      p_vld <= req_valid;
      p_rdy <= req_ready;
      p_a   <= req_a;
      p_b   <= req_b;
      p_sub <= req_sub;
      p_ok  <= !rst;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic s);
      req_valid[i]        = v;
      req_a[i*16 +: 16]   = a;
      req_b[i*16 +: 16]   = b;
      req_sub[i]          = s;
   endtask

   logic [15:0] rr_a   [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
   logic [15:0] rr_b   [4] = '{16'h0001, 16'h0222, 16'h4DDD, 16'hC444};
   logic        rr_s   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [15:0] rr_z   [4] = '{16'h1112, 16'h2000, 16'h8110, 16'h8000};
   logic        rr_o   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst       = 1'b1;
      issue_en  = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;

      #12;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_z", 32'(rsp_z), 32'h0);
      chk("rst_rsp_ovf", 32'(rsp_ovf), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_core_A", 32'(core_A), 32'h0);
      chk("rst_core_B", 32'(core_B), 32'h0);
      chk("rst_core_AddSub", 32'(core_AddSub), 32'h0);
      chk("rst_core_Sel", 32'(core_Sel), 32'h0);
      cyc();
      rst = 1'b0;

      // single add
      set_req(0, 1'b1, 16'h0003, 16'h0004, 1'b0);
      #1;
      chk("add_ready", 32'(req_ready), 32'h1);
      chk("add_core_A", 32'(core_A), 32'h3);
      chk("add_core_B", 32'(core_B), 32'h4);
      chk("add_busy0", 32'(busy), 32'h0);
      cyc();
      set_req(0, 1'b0, 16'h0003, 16'h0004, 1'b0);
      #1;
      chk("add_busy1", 32'(busy), 32'h1);
      chk("add_rsp_early", 32'(rsp_valid), 32'h0);
      cyc();
      #1;
      chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("add_rsp_z", 32'(rsp_z), 32'h7);
      chk("add_rsp_ovf", 32'(rsp_ovf), 32'h0);

      // overflow add then subtract, back to back
      cyc();
      set_req(1, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
      #1;
      chk("ovf_ready", 32'(req_ready), 32'h2);
      cyc();
      set_req(1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
      set_req(2, 1'b1, 16'h0005, 16'h0007, 1'b1);
      #1;
      chk("sub_ready", 32'(req_ready), 32'h4);
      chk("sub_core_AddSub", 32'(core_AddSub), 32'h1);
      cyc();
      set_req(2, 1'b0, 16'h0005, 16'h0007, 1'b1);
      #1;
      chk("ovf_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("ovf_rsp_z", 32'(rsp_z), 32'h8000);
      chk("ovf_rsp_ovf", 32'(rsp_ovf), 32'h1);
      cyc();
      #1;
      chk("sub_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("sub_rsp_z", 32'(rsp_z), 32'hFFFE);
      chk("sub_rsp_ovf", 32'(rsp_ovf), 32'h0);

      // wrap-around: pointer sits at 3
      cyc();
      set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
      set_req(3, 1'b1, 16'h0002, 16'h0002, 1'b0);
      #1;
      chk("wrap_ready3", 32'(req_ready), 32'h8);
      cyc();
      set_req(3, 1'b0, 16'h0002, 16'h0002, 1'b0);
      #1;
      chk("wrap_ready0", 32'(req_ready), 32'h1);
      cyc();
      set_req(0, 1'b0, 16'h0001, 16'h0001, 1'b0);
      #1;
      chk("wrap_ready_none", 32'(req_ready), 32'h0);
      chk("wrap_rsp3_valid", 32'(rsp_valid), 32'h8);
      chk("wrap_rsp3_z", 32'(rsp_z), 32'h4);
      cyc();
      #1;
      chk("wrap_rsp0_valid", 32'(rsp_valid), 32'h1);
      chk("wrap_rsp0_z", 32'(rsp_z), 32'h2);

      // issue_en gating with pointer at 1 and only req3 pending
      cyc();
      issue_en = 1'b0;
      set_req(3, 1'b1, 16'h8000, 16'h0001, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("gate_ready_%0d", k), 32'(req_ready), 32'h0);
         chk($sformatf("gate_core_A_%0d", k), 32'(core_A), 32'h0);
         cyc();
      end
      issue_en = 1'b1;
      #1;
      chk("gate_ready_open", 32'(req_ready), 32'h8);
      chk("gate_core_A_open", 32'(core_A), 32'h8000);
      cyc();
      set_req(3, 1'b0, 16'h8000, 16'h0001, 1'b1);
      #1;
      chk("gate_rsp_early", 32'(rsp_valid), 32'h0);
      cyc();
      #1;
      chk("gate_rsp_valid", 32'(rsp_valid), 32'h8);
      chk("gate_rsp_z", 32'(rsp_z), 32'h7FFF);
      chk("gate_rsp_ovf", 32'(rsp_ovf), 32'h1);

      // round-robin: every requester issues twice, pointer starts at 0
      cyc();
      for (int i = 0; i < 4; i++)
         set_req(i, 1'b0, rr_a[i], rr_b[i], rr_s[i]);
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 4; i++)
            req_valid[i] = (k < 8) && (k <= 4 + i);
         #1;
         if (k < 8)
            chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         if (k >= 2) begin
            chk($sformatf("rr_rsp_valid_%0d", k), 32'(rsp_valid), 32'(4'b0001 << ((k - 2) % 4)));
            chk($sformatf("rr_rsp_z_%0d", k), 32'(rsp_z), 32'(rr_z[(k - 2) % 4]));
            chk($sformatf("rr_rsp_ovf_%0d", k), 32'(rsp_ovf), 32'(rr_o[(k - 2) % 4]));
         end
         cyc();
      end
      #1;
      chk("rr_busy_drained", 32'(busy), 32'h0);

      // reset while an operation is in flight
      set_req(0, 1'b1, 16'h0010, 16'h0020, 1'b0);
      #1;
      chk("mid_ready", 32'(req_ready), 32'h1);
      cyc();
      set_req(0, 1'b0, 16'h0010, 16'h0020, 1'b0);
      #1;
      chk("mid_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid_rst_core_A", 32'(core_A), 32'h0);
      set_req(0, 1'b1, 16'h0010, 16'h0020, 1'b0);
      set_req(2, 1'b1, 16'h0003, 16'h0004, 1'b0);
      #1;
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      cyc();
      #1;
      chk("mid_lost_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid_lost_rsp_z", 32'(rsp_z), 32'h0);
      cyc();
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'h1);
      cyc();
      set_req(0, 1'b0, 16'h0010, 16'h0020, 1'b0);
      #1;
      chk("post_rst_ready2", 32'(req_ready), 32'h4);
      cyc();
      set_req(2, 1'b0, 16'h0003, 16'h0004, 1'b0);
      #1;
      chk("post_rst_rsp0_valid", 32'(rsp_valid), 32'h1);
      chk("post_rst_rsp0_z", 32'(rsp_z), 32'h30);
      cyc();
      #1;
      chk("post_rst_rsp2_valid", 32'(rsp_valid), 32'h4);
      chk("post_rst_rsp2_z", 32'(rsp_z), 32'h7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one registered 16-bit `addersubtractor` core between NUM_REQ independent requesters.
- Issues at most one operation per cycle, chosen round-robin. Tracks in-flight operations with a tag pipeline matched to the core latency.
- Returns each result and overflow flag to the requester that issued it.
- Sits in the core domain between the requesters and the `addersubtractor` instance, driving its A/B/AddSub/Sel inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width; must equal core width.
- CORE_LATENCY, 2, cycles from operands presented on core_A/core_B to valid core_Z/core_Overflow (≥1).

Ports:
- Clock  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- issue_en  input  1  1 = grants allowed; 0 = no new grants, in-flight ops still complete.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_ready  output  NUM_REQ  one-hot grant; a request transfers when valid&ready.
- req_a  input  NUM_REQ*WIDTH  operand A, slice i for requester i.
- req_b  input  NUM_REQ*WIDTH  operand B, slice i.
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B.
- rsp_valid  output  NUM_REQ  one-hot response pulse.
- rsp_z  output  WIDTH  result, shared by all requesters, qualified by rsp_valid.
- rsp_ovf  output  1  signed overflow, qualified by rsp_valid.
- core_A  output  WIDTH  to core A.
- core_B  output  WIDTH  to core B.
- core_AddSub  output  1  to core AddSub (1 = subtract).
- core_Sel  output  1  to core Sel; tied 0 (no accumulate mode).
- core_Z  input  WIDTH  from core Z.
- core_Overflow  input  1  from core Overflow.
- busy  output  1  1 while any tag is in flight.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rr_ptr=0 and all tag stages cleared.
  - req_ready=0, rsp_valid=0, rsp_z=0, rsp_ovf=0, busy=0.
  - core_A=0, core_B=0, core_AddSub=0, core_Sel=0.
- Arbitration (combinational, same cycle):
  - If issue_en=1, search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit g is granted and req_ready[g]=1; all other ready bits are 0.
  - No valid request or issue_en=0 → req_ready all 0.
- Core drive:
  - On grant g: core_A=req_a[g], core_B=req_b[g], core_AddSub=req_sub[g].
  - No grant: core_A=0, core_B=0, core_AddSub=0.
  - core_Sel is constant 0.
- Pointer:
  - On a grant to g, rr_ptr <= (g+1) mod NUM_REQ at the next edge.
  - No grant: rr_ptr holds.
- Tag pipeline:
  - CORE_LATENCY-deep shift register of {valid, id[clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {1,g} on grant, else {0,x}; it shifts every cycle.
- Response:
  - When the last stage has valid=1 with id=k: rsp_valid[k]=1, rsp_z=core_Z, rsp_ovf=core_Overflow, all combinational from the core in that cycle.
  - A grant accepted in cycle t produces its response in cycle t+CORE_LATENCY.
  - Otherwise rsp_valid=0, rsp_z=0, rsp_ovf=0.
- Ordering and backpressure:
  - Responses are in issue order. Back-to-back grants give back-to-back responses, one per cycle.
  - There is no response backpressure; requesters must accept rsp_valid unconditionally.
- Requester rule: while req_valid[i]=1 and req_ready[i]=0, req_a/req_b/req_sub slice i must stay stable, and the requester must not withdraw req_valid. The bench asserts this.
- A requester may have multiple operations outstanding.
- busy is the OR of the tag valid bits.
- issue_en falling mid-stream: no new grants; outstanding tags drain normally.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. Ops resume from rr_ptr=0 after reset.
- Simultaneous grant and response in one cycle is normal. The response id is independent of the current grant.
- Arithmetic: two's complement, mod 2^WIDTH; overflow is signed overflow as reported by the core. The arbiter does no arithmetic of its own.

Test Plan:
- Single add: reset, req0 valid, a=0x0003, b=0x0004, sub=0.
  - req_ready=0001 same cycle; 2 cycles later rsp_valid=0001, rsp_z=0x0007, rsp_ovf=0.
- Overflow and subtract:
  - req1 a=0x7FFF, b=0x0001, add → rsp_valid=0010, rsp_z=0x8000, rsp_ovf=1.
  - req2 a=0x0005, b=0x0007, sub → rsp_z=0xFFFE, rsp_ovf=0.
- Round-robin: all four requesters valid continuously for 8 cycles.
  - Grants 0,1,2,3,0,1,2,3; responses appear in the same order starting 2 cycles after the first grant, one per cycle.
- issue_en gating: req3 valid with issue_en=0 for 5 cycles.
  - req_ready stays 0 and operands are held stable. The cycle issue_en rises, req_ready=1000; response follows 2 cycles later.
- Reset mid-flight: grant req0 (0x0010+0x0020), then assert Reset one cycle later.
  - All outputs go to zero immediately. No rsp_valid for the lost op; busy=0. After release, the first grant goes to the lowest valid index.
- Wrap-around: rr_ptr=3 after granting req2; req0 and req3 both valid.
  - req3 granted first, then req0; rr_ptr becomes 1.
